mandelbrot_sequencer: RTL

Frame-level controller that sits between the host/register interface and the `mandelbrot` pixel engine. It loads frame parameters into the engine, issues one `run` pulse per pixel, and captures each pixel's 4-bit iteration code into a one-entry output buffer with a valid/ready handshake. Between frames it optionally applies zoom and pan updates so the engine renders an animated sequence without host intervention.

---
 rtl/mandelbrot_pkg.sv | 23 ++
 rtl/mandelbrot_sequencer_if.sv | 20 ++
 rtl/mandelbrot_pixel_counter.sv | 47 ++++
 rtl/mandelbrot_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mandelbrot_pkg.sv
// Shared definitions for the mandelbrot frame sequencer and pixel engine.
package mandelbrot_pkg;

    localparam int unsigned SCALING_W  = 7;
    localparam int unsigned DEF_WIDTH  = 320;
    localparam int unsigned DEF_HEIGHT = 240;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_FRAME_END
    } seq_state_t;

    // Scaling decrement that stops at zero instead of wrapping.
    function automatic logic [SCALING_W-1:0] sat_sub(input logic [SCALING_W-1:0] a,
                                                     input logic [SCALING_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/mandelbrot_sequencer_if.sv
// Pixel output stream: one-entry buffer with valid/ready handshake.
interface mandelbrot_sequencer_if;

    logic [3:0] pix_data;
    logic       pix_valid;
    logic       pix_ready;
    logic       pix_sol;
    logic       pix_last;

    modport master (
        output pix_data, pix_valid, pix_sol, pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_data, pix_valid, pix_sol, pix_last,
        output pix_ready
    );

endinterface

// File: rtl/mandelbrot_pixel_counter.sv
// x/y raster position counter with first-of-line and last-of-frame flags.
module mandelbrot_pixel_counter
    import mandelbrot_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned HEIGHT = DEF_HEIGHT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_advance,
    output logic o_sol,
    output logic o_last
);

    localparam int unsigned XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          w_x_end;
    logic          w_y_end;

    assign w_x_end = (r_x == XW'(WIDTH - 1));
    assign w_y_end = (r_y == YW'(HEIGHT - 1));
    assign o_sol   = (r_x == '0);
    assign o_last  = w_x_end & w_y_end;

    // Raster scan: x runs fastest, wrapping to the origin after the last pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_advance) begin
            if (w_x_end) begin
                r_x <= '0;
                r_y <= w_y_end ? '0 : (r_y + YW'(1));
            end else begin
                r_x <= r_x + XW'(1);
            end
        end
    end

endmodule

// File: rtl/mandelbrot_sequencer.sv
// Frame-level controller for the mandelbrot pixel engine.
// Optional feature macro: MANDEL_SEQ_ZOOM_EN (per-frame zoom/pan update).
module mandelbrot_sequencer
    import mandelbrot_pkg::*;
#(
    parameter int unsigned BITWIDTH = 10,
    parameter int unsigned CTRWIDTH = 7,
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned HEIGHT   = DEF_HEIGHT,
    parameter int unsigned FCNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 continuous,
    input  logic [SCALING_W-1:0] init_scaling,
    input  logic [BITWIDTH-1:0]  init_cr,
    input  logic [BITWIDTH-1:0]  init_ci,
    input  logic [CTRWIDTH-1:0]  init_max_ctr,
    input  logic [SCALING_W-1:0] zoom_step,
    input  logic [BITWIDTH-1:0]  pan_cr,
    input  logic [BITWIDTH-1:0]  pan_ci,
    output logic                 eng_run,
    input  logic                 eng_running,
    input  logic                 eng_finished,
    input  logic [3:0]           eng_ctr_out,
    output logic [SCALING_W-1:0] eng_scaling,
    output logic [BITWIDTH-1:0]  eng_cr_offset,
    output logic [BITWIDTH-1:0]  eng_ci_offset,
    output logic [CTRWIDTH-1:0]  eng_max_ctr,
    mandelbrot_sequencer_if.master pix,
    output logic                 busy,
    output logic                 frame_done,
    output logic [FCNT_W-1:0]    frame_count
);

    seq_state_t           r_state;
    logic                 r_stop;
    logic                 r_run_prev;
    logic                 r_eng_run;
    logic [SCALING_W-1:0] r_scaling;
    logic [BITWIDTH-1:0]  r_cr;
    logic [BITWIDTH-1:0]  r_ci;
    logic [CTRWIDTH-1:0]  r_max_ctr;
    logic [3:0]           r_pix_data;
    logic                 r_pix_valid;
    logic                 r_pix_sol;
    logic                 r_pix_last;
    logic                 r_busy;
    logic                 r_frame_done;
    logic [FCNT_W-1:0]    r_frame_count;

    logic w_clear;
    logic w_advance;
    logic w_sol;
    logic w_last;

`ifndef MANDEL_SEQ_ZOOM_EN
    logic w_unused_zoom;
    assign w_unused_zoom = ^{zoom_step, pan_cr, pan_ci};
`endif

    assign w_clear   = (r_state == S_IDLE) && start;
    assign w_advance = (r_state == S_HOLD) && pix.pix_ready;

    mandelbrot_pixel_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_pixel_counter (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_clear),
        .i_advance (w_advance),
        .o_sol     (w_sol),
        .o_last    (w_last)
    );

    assign eng_run       = r_eng_run;
    assign eng_scaling   = r_scaling;
    assign eng_cr_offset = r_cr;
    assign eng_ci_offset = r_ci;
    assign eng_max_ctr   = r_max_ctr;
    assign pix.pix_data  = r_pix_data;
    assign pix.pix_valid = r_pix_valid;
    assign pix.pix_sol   = r_pix_sol;
    assign pix.pix_last  = r_pix_last;
    assign busy          = r_busy;
    assign frame_done    = r_frame_done;
    assign frame_count   = r_frame_count;

    // Frame sequencing FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_stop        <= 1'b0;
            r_run_prev    <= 1'b0;
            r_eng_run     <= 1'b0;
            r_scaling     <= '0;
            r_cr          <= '0;
            r_ci          <= '0;
            r_max_ctr     <= '0;
            r_pix_data    <= '0;
            r_pix_valid   <= 1'b0;
            r_pix_sol     <= 1'b0;
            r_pix_last    <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_run_prev   <= eng_running;
            r_eng_run    <= 1'b0;
            r_frame_done <= 1'b0;
            if ((r_state != S_IDLE) && stop) begin
                r_stop <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_scaling     <= init_scaling;
                        r_cr          <= init_cr;
                        r_ci          <= init_ci;
                        r_max_ctr     <= init_max_ctr;
                        r_frame_count <= '0;
                        r_stop        <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_eng_run <= 1'b1;
                    r_state   <= S_ISSUE;
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_run_prev && !eng_running) begin
                        r_pix_data  <= eng_ctr_out;
                        r_pix_valid <= 1'b1;
                        r_pix_sol   <= w_sol;
                        r_pix_last  <= w_last;
                        r_state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (pix.pix_ready) begin
                        r_pix_valid <= 1'b0;
                        if (r_pix_last) begin
                            // Frame bookkeeping is done on the accepting edge so that
                            // frame_done, frame_count and the new eng_* values all
                            // appear together in the FRAME_END cycle.
                            r_frame_done  <= 1'b1;
                            r_frame_count <= r_frame_count + FCNT_W'(1);
`ifdef MANDEL_SEQ_ZOOM_EN
                            r_scaling <= sat_sub(r_scaling, zoom_step);
                            r_cr      <= r_cr + pan_cr;
                            r_ci      <= r_ci + pan_ci;
`endif
                            r_state <= S_FRAME_END;
                        end else begin
                            r_eng_run <= 1'b1;
                            r_state   <= S_ISSUE;
                        end
                    end
                end
                S_FRAME_END: begin
                    if (r_stop || stop || !continuous) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_LOAD;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The engine should only report frame completion on the last pixel.
    a_finished_early: assert property (@(posedge clk) disable iff (rst)
        !((r_state == S_HOLD) && eng_finished && !r_pix_last))
        else $error("mandelbrot_sequencer: engine finished before pixel counter reached last");

endmodule
